wb_data_cache: RTL and testbench
================================

# wb_data_cache

Parametrised direct-mapped, write-back, write-allocate data cache for the RV32I core's MEM stage, replacing the flat single-cycle data memory. Hits complete with the same one-cycle synchronous read latency as the flat memory. Misses stall the pipeline through `miss` while a line-wide handshake with main memory evicts dirty lines and refills. Access and miss counters are exposed for hit-rate measurement.

## Interface
Parameters:
- `LINE_ADDR_LEN`, 3, log2 of words per line (8 words = 32 B).
- `SET_ADDR_LEN`, 3, log2 of number of sets.
- `TAG_ADDR_LEN`, 6, tag bits. Constraint: 2+LINE+SET+TAG ≤ 32; defaults cover 16 KB.

Ports (clock is `clk`; reset is `rst_n`, synchronous, active-low):
- `clk` in 1: clock, all state on rising edge.
- `rst_n` in 1: synchronous active-low reset.
- `rd_req` in 1: load request, held by core while `miss`=1.
- `wr_req` in 1: store request, held while `miss`=1.
- `addr` in 32: byte address; [1:0] ignored.
- `wr_be` in 4: byte enables for store.
- `wr_data` in 32: store data.
- `rd_data` out 32: load data, registered.
- `miss` out 1: combinational stall to core.
- `mem_req` out 1: memory request, held until `mem_gnt`.
- `mem_we` out 1: 1 = line write-back, 0 = line fetch.
- `mem_addr` out TAG+SET: line address {tag,set}.
- `mem_wdata` out 32·2^LINE: evicted line, word 0 in LSBs.
- `mem_rdata` in 32·2^LINE: fetched line, valid in the `mem_gnt` cycle.
- `mem_gnt` in 1: one-cycle completion pulse, ≥1 cycle after `mem_req` rises.
- `acc_cnt` out 32: completed in-range accesses.
- `miss_cnt` out 32: refills started.

## Operation
- Address split: word = addr[2+LINE-1:2], set = next SET bits, tag = next TAG bits. Bits above the tag must be zero (in range).
- Out of range: load returns 0, store dropped, `miss`=0, counters unchanged.
- Storage: per set one valid bit, one dirty bit, a tag and a line. The data array is not reset.
- FSM states: IDLE, SWAP_OUT, SWAP_IN, SWAP_IN_OK.
- IDLE with a request that hits (valid and tag equal):
  - `miss`=0.
  - Load: `rd_data` ← word at the clock edge.
  - Store: bytes with `wr_be`=1 written, dirty ← 1.
  - `acc_cnt`++.
- IDLE with a request that misses:
  - `miss`=1, `miss_cnt`++.
  - Next state SWAP_OUT if valid and dirty, else SWAP_IN.
- SWAP_OUT:
  - `mem_req`=1, `mem_we`=1, `mem_addr`={old tag,set}, `mem_wdata`=line.
  - On `mem_gnt` → SWAP_IN.
- SWAP_IN:
  - `mem_req`=1, `mem_we`=0, `mem_addr`={req tag,set}.
  - On `mem_gnt` capture `mem_rdata` → SWAP_IN_OK.
- SWAP_IN_OK: install line, tag ← req tag, valid ← 1, dirty ← 0 → IDLE. The held request then hits.
- `miss`=1 in every non-IDLE state, and in IDLE whenever an in-range request misses.
- `rd_req` and `wr_req` both high: handled as a store; `rd_data` also loads the pre-write word.
- No request in IDLE: `rd_data` holds its value.
- Counters saturate at 32'hFFFF_FFFF.

## Timing
- Reset values: state IDLE, all valid = 0, all dirty = 0, `rd_data`=0, `mem_req`=0, `mem_we`=0, `acc_cnt`=0, `miss_cnt`=0. `miss`=0 when no request.
- Hit: request in cycle N, `rd_data` valid in N+1.
- Clean miss, `mem_gnt` at latency G: request in N, SWAP_IN N+1..N+G, SWAP_IN_OK N+G+1, hit N+G+2, data N+G+3.
- Dirty miss adds the SWAP_OUT duration.
- `mem_req` drops the cycle after `mem_gnt`, except SWAP_OUT→SWAP_IN, where it stays high with `mem_we` changing to 0.
- Request inputs are sampled only in IDLE; changes during a stall are a core protocol violation and are undefined.
- Reset mid-operation: next cycle is IDLE, `mem_req`=0, all lines invalid. The pending memory transaction is abandoned and a late `mem_gnt` is ignored.

## Test plan
- Reset, load 0x0000_0040, memory line word0 = 0x1111_1111, `mem_gnt` after 3 cycles -> `mem_req`/`mem_we`=1/0, `mem_addr`=0x002; `miss` falls; `rd_data`=0x1111_1111; `miss_cnt`=1, `acc_cnt`=1.
- Load 0x44 (word1 = 0x2222_2222), then store 0x44 with `wr_be`=0011 and data 0xAAAA_BBBB, then load 0x44 -> `rd_data`=0x2222_BBBB; no `mem_req`; `acc_cnt`=4.
- Load 0x0000_0140 (same set, tag 1) -> write-back `mem_addr`=0x002 with `mem_wdata` word1 = 0x2222_BBBB, then fetch `mem_addr`=0x00A; `miss_cnt`=2.
- Store 0x0000_4000 data 0xDEAD_BEEF, then load 0x0000_4000 -> `miss`=0, `rd_data`=0, counters unchanged, no `mem_req`.
- Pull `rst_n` low during SWAP_IN before `mem_gnt` -> next cycle `mem_req`=0, `rd_data`=0, counters 0; reload of 0x40 misses again.
- Load and store at 0x48 simultaneously, data 0x5555_5555, `wr_be`=1111 -> `rd_data`=old word; a following load returns 0x5555_5555.

Source files
------------

// File: rtl/wb_data_cache.sv
// rtl/wb_data_cache.sv - direct-mapped write-back write-allocate data cache
// Hits return data one cycle after the request; misses stall through miss while lines swap.
module wb_data_cache #(
   parameter int LINE_ADDR_LEN = 3,
   parameter int SET_ADDR_LEN  = 3,
   parameter int TAG_ADDR_LEN  = 6
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   rd_req,
   input  logic                                   wr_req,
   input  logic [31:0]                            addr,
   input  logic [3:0]                             wr_be,
   input  logic [31:0]                            wr_data,
   output logic [31:0]                            rd_data,
   output logic                                   miss,
   output logic                                   mem_req,
   output logic                                   mem_we,
   output logic [TAG_ADDR_LEN+SET_ADDR_LEN-1:0]   mem_addr,
   output logic [32*(2**LINE_ADDR_LEN)-1:0]       mem_wdata,
   input  logic [32*(2**LINE_ADDR_LEN)-1:0]       mem_rdata,
   input  logic                                   mem_gnt,
   output logic [31:0]                            acc_cnt,
   output logic [31:0]                            miss_cnt
);
   localparam int WORDS = 2**LINE_ADDR_LEN;
   localparam int SETS  = 2**SET_ADDR_LEN;
   localparam int OFF   = 2 + LINE_ADDR_LEN;
   localparam int HI    = OFF + SET_ADDR_LEN + TAG_ADDR_LEN;

   typedef enum logic [1:0] {IDLE, SWAP_OUT, SWAP_IN, SWAP_IN_OK} state_t;
   state_t state, state_nxt;

   logic                      valid [SETS];
   logic                      dirty [SETS];
   logic [TAG_ADDR_LEN-1:0]   tags  [SETS];
   logic [31:0]               lines [SETS][WORDS];
   logic [32*WORDS-1:0]       fill_buf;

   logic [LINE_ADDR_LEN-1:0]  word_idx;
   logic [SET_ADDR_LEN-1:0]   set_idx;
   logic [TAG_ADDR_LEN-1:0]   tag;
   logic                      in_range, req, hit, hit_acc, start_miss;
   logic                      unused_addr;

   assign word_idx    = addr[OFF-1:2];
   assign set_idx     = addr[OFF+SET_ADDR_LEN-1:OFF];
   assign tag         = addr[HI-1:OFF+SET_ADDR_LEN];
   assign unused_addr = ^addr[1:0];

   generate
      if (HI < 32) begin : g_range
         assign in_range = ~|addr[31:HI];
      end else begin : g_full
         assign in_range = 1'b1;
      end
   endgenerate

   assign req        = rd_req | wr_req;
   assign hit        = valid[set_idx] && (tags[set_idx] == tag);
   assign hit_acc    = (state == IDLE) && req && in_range && hit;
   assign start_miss = (state == IDLE) && req && in_range && !hit;

   always_comb begin
      state_nxt = state;
      miss      = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = {tag, set_idx};
      case (state)
         IDLE: begin
            if (start_miss) begin
               miss      = 1'b1;
               state_nxt = (valid[set_idx] && dirty[set_idx]) ? SWAP_OUT : SWAP_IN;
            end
         end
         SWAP_OUT: begin
            miss     = 1'b1;
            mem_req  = 1'b1;
            mem_we   = 1'b1;
            mem_addr = {tags[set_idx], set_idx};
            if (mem_gnt) state_nxt = SWAP_IN;
         end
         SWAP_IN: begin
            miss    = 1'b1;
            mem_req = 1'b1;
            if (mem_gnt) state_nxt = SWAP_IN_OK;
         end
         SWAP_IN_OK: begin
            miss      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      mem_wdata = '0;
      for (int w = 0; w < WORDS; w++) mem_wdata[32*w +: 32] = lines[set_idx][w];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         rd_data  <= 32'd0;
         acc_cnt  <= 32'd0;
         miss_cnt <= 32'd0;
         for (int i = 0; i < SETS; i++) begin
            valid[i] <= 1'b0;
            dirty[i] <= 1'b0;
         end
      end else begin
         state <= state_nxt;
         if ((state == IDLE) && rd_req && !in_range) rd_data <= 32'd0;
         if (hit_acc) begin
            if (rd_req) rd_data <= lines[set_idx][word_idx];
            if (wr_req) dirty[set_idx] <= 1'b1;
            if (acc_cnt != 32'hFFFF_FFFF) acc_cnt <= acc_cnt + 32'd1;
         end
         if (start_miss && (miss_cnt != 32'hFFFF_FFFF)) miss_cnt <= miss_cnt + 32'd1;
         if (state == SWAP_IN_OK) begin
            valid[set_idx] <= 1'b1;
            dirty[set_idx] <= 1'b0;
         end
      end
   end

   // Tags and line data carry no reset; valid bits alone qualify them.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if ((state == SWAP_IN) && mem_gnt) fill_buf <= mem_rdata;
         if (state == SWAP_IN_OK) begin
            tags[set_idx] <= tag;
            for (int w = 0; w < WORDS; w++) lines[set_idx][w] <= fill_buf[32*w +: 32];
         end
         if (hit_acc && wr_req) begin
            for (int b = 0; b < 4; b++)
               if (wr_be[b]) lines[set_idx][word_idx][8*b +: 8] <= wr_data[8*b +: 8];
         end
      end
   end
endmodule

// File: tb/tb_wb_data_cache.sv
// tb/tb_wb_data_cache.sv - randomized self-checking bench for wb_data_cache
// Transaction-level cache and memory model predicts every cycle of each access.
module tb_wb_data_cache;
   localparam int NS  = 8;
   localparam int WPL = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          rd_req = 1'b0, wr_req = 1'b0;
   logic [31:0]   addr = 32'd0;
   logic [3:0]    wr_be = 4'd0;
   logic [31:0]   wr_data = 32'd0;
   logic [31:0]   rd_data;
   logic          miss, mem_req, mem_we;
   logic [8:0]    mem_addr;
   logic [255:0]  mem_wdata;
   logic [255:0]  mem_rdata = '0;
   logic          mem_gnt = 1'b0;
   logic [31:0]   acc_cnt, miss_cnt;

   wb_data_cache dut (
      .clk(clk), .rst_n(rst_n), .rd_req(rd_req), .wr_req(wr_req), .addr(addr),
      .wr_be(wr_be), .wr_data(wr_data), .rd_data(rd_data), .miss(miss),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_gnt(mem_gnt), .acc_cnt(acc_cnt), .miss_cnt(miss_cnt)
   );

   always #5 clk = ~clk;

   int            checks = 0;
   int            failures = 0;
   logic          m_valid [NS];
   logic          m_dirty [NS];
   logic [5:0]    m_tag   [NS];
   logic [31:0]   m_line  [NS][WPL];
   logic [31:0]   mem_m   [int];
   logic [31:0]   m_rd, m_acc, m_miss;
   logic [8:0]    last_fetch, last_wb;
   logic [31:0]   last_wb_w1;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   function automatic logic [31:0] mem_word(input logic [8:0] la, input int w);
      int key;
      key = int'(la) * WPL + w;
      if (mem_m.exists(key)) return mem_m[key];
      return (32'(key) * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic logic [255:0] mem_line(input logic [8:0] la);
      logic [255:0] r;
      for (int w = 0; w < WPL; w++) r[32*w +: 32] = mem_word(la, w);
      return r;
   endfunction

   function automatic logic [255:0] pack_line(input logic [2:0] s);
      logic [255:0] r;
      for (int w = 0; w < WPL; w++) r[32*w +: 32] = m_line[s][w];
      return r;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < NS; i++) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
      end
      m_rd = 32'd0; m_acc = 32'd0; m_miss = 32'd0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; rd_req = 1'b0; wr_req = 1'b0; mem_gnt = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_clear();
   endtask

   task automatic idle_cycle();
      @(negedge clk);
      #1;
      chk("idle_miss", 256'(miss), 256'(0));
      chk("idle_mem_req", 256'(mem_req), 256'(0));
      chk("idle_rd_data", 256'(rd_data), 256'(m_rd));
   endtask

   // One core access; g_in > 0 fixes the memory grant latency, else it is random.
   task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                         input logic [3:0] be, input logic [31:0] d, input int g_in);
      logic [2:0] s, wd;
      logic [5:0] tg;
      logic [8:0] la;
      logic [255:0] line_v;
      bit inr, hit;
      int g;
      inr = (a[31:14] == 18'd0);
      wd = a[4:2]; s = a[7:5]; tg = a[13:8];
      @(negedge clk);
      rd_req = rd; wr_req = wr; addr = a; wr_be = be; wr_data = d;
      #1;
      hit = m_valid[s] && (m_tag[s] == tg);
      chk("req_miss", 256'(miss), 256'(inr && !hit));
      chk("req_mem_req", 256'(mem_req), 256'(0));
      if (inr && !hit) begin
         m_miss = sat_inc(m_miss);
         if (m_valid[s] && m_dirty[s]) begin
            line_v = pack_line(s);
            la = {m_tag[s], s};
            last_wb = la;
            last_wb_w1 = m_line[s][1];
            g = (g_in > 0) ? g_in : int'($urandom_range(1, 4));
            for (int c = 1; c <= g; c++) begin
               @(negedge clk);
               chk("wb_req", 256'(mem_req), 256'(1));
               chk("wb_we", 256'(mem_we), 256'(1));
               chk("wb_addr", 256'(mem_addr), 256'(la));
               chk("wb_wdata", mem_wdata, line_v);
               chk("wb_miss", 256'(miss), 256'(1));
               if (c == g) mem_gnt = 1'b1;
            end
            for (int w = 0; w < WPL; w++) mem_m[int'(la) * WPL + w] = m_line[s][w];
         end
         la = {tg, s};
         last_fetch = la;
         g = (g_in > 0) ? g_in : int'($urandom_range(1, 4));
         for (int c = 1; c <= g; c++) begin
            @(negedge clk);
            mem_gnt = 1'b0;
            chk("rf_req", 256'(mem_req), 256'(1));
            chk("rf_we", 256'(mem_we), 256'(0));
            chk("rf_addr", 256'(mem_addr), 256'(la));
            chk("rf_miss", 256'(miss), 256'(1));
            if (c == g) begin
               mem_gnt = 1'b1;
               mem_rdata = mem_line(la);
            end
         end
         @(negedge clk);
         mem_gnt = 1'b0;
         mem_rdata = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         #1;
         chk("ok_mem_req", 256'(mem_req), 256'(0));
         chk("ok_miss", 256'(miss), 256'(1));
         m_valid[s] = 1'b1; m_dirty[s] = 1'b0; m_tag[s] = tg;
         for (int w = 0; w < WPL; w++) m_line[s][w] = mem_word(la, w);
         @(negedge clk);
         #1;
         chk("rehit_miss", 256'(miss), 256'(0));
         chk("rehit_mem_req", 256'(mem_req), 256'(0));
      end
      if (inr) begin
         if (rd) m_rd = m_line[s][wd];
         if (wr) begin
            for (int b = 0; b < 4; b++)
               if (be[b]) m_line[s][wd][8*b +: 8] = d[8*b +: 8];
            m_dirty[s] = 1'b1;
         end
         m_acc = sat_inc(m_acc);
      end else if (rd) begin
         m_rd = 32'd0;
      end
      @(negedge clk);
      rd_req = 1'b0; wr_req = 1'b0;
      #1;
      chk("rd_data", 256'(rd_data), 256'(m_rd));
      chk("acc_cnt", 256'(acc_cnt), 256'(m_acc));
      chk("miss_cnt", 256'(miss_cnt), 256'(m_miss));
      chk("post_mem_req", 256'(mem_req), 256'(0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      int op;
      model_clear();
      do_reset();
      #1;
      chk("rst_rd_data", 256'(rd_data), 256'(0));
      chk("rst_mem_req", 256'(mem_req), 256'(0));
      chk("rst_mem_we", 256'(mem_we), 256'(0));
      chk("rst_miss", 256'(miss), 256'(0));
      chk("rst_acc", 256'(acc_cnt), 256'(0));
      chk("rst_miss_cnt", 256'(miss_cnt), 256'(0));

      mem_m[2 * WPL + 0] = 32'h1111_1111;
      mem_m[2 * WPL + 1] = 32'h2222_2222;
      access(1'b1, 1'b0, 32'h0000_0040, 4'h0, 32'd0, 3);
      chk("tp1_rd", 256'(rd_data), 256'(32'h1111_1111));
      chk("tp1_fetch", 256'(last_fetch), 256'(9'h002));
      chk("tp1_misses", 256'(miss_cnt), 256'(1));
      chk("tp1_accs", 256'(acc_cnt), 256'(1));

      access(1'b1, 1'b0, 32'h0000_0044, 4'h0, 32'd0, 0);
      chk("tp2_ld", 256'(rd_data), 256'(32'h2222_2222));
      access(1'b0, 1'b1, 32'h0000_0044, 4'b0011, 32'hAAAA_BBBB, 0);
      access(1'b1, 1'b0, 32'h0000_0044, 4'h0, 32'd0, 0);
      chk("tp2_merge", 256'(rd_data), 256'(32'h2222_BBBB));
      chk("tp2_accs", 256'(acc_cnt), 256'(4));

      access(1'b1, 1'b0, 32'h0000_0140, 4'h0, 32'd0, 0);
      chk("tp3_wb_addr", 256'(last_wb), 256'(9'h002));
      chk("tp3_wb_w1", 256'(last_wb_w1), 256'(32'h2222_BBBB));
      chk("tp3_fetch", 256'(last_fetch), 256'(9'h00A));
      chk("tp3_misses", 256'(miss_cnt), 256'(2));

      access(1'b0, 1'b1, 32'h0000_4000, 4'hF, 32'hDEAD_BEEF, 0);
      access(1'b1, 1'b0, 32'h0000_4000, 4'h0, 32'd0, 0);
      chk("tp4_rd", 256'(rd_data), 256'(0));
      chk("tp4_accs", 256'(acc_cnt), 256'(5));
      chk("tp4_misses", 256'(miss_cnt), 256'(2));

      @(negedge clk);
      rd_req = 1'b1; addr = 32'h0000_0040;
      @(negedge clk);
      chk("tp5_swap_in", 256'(mem_req), 256'(1));
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1; rd_req = 1'b0;
      model_clear();
      #1;
      chk("tp5_mem_req", 256'(mem_req), 256'(0));
      chk("tp5_rd", 256'(rd_data), 256'(0));
      chk("tp5_accs", 256'(acc_cnt), 256'(0));
      chk("tp5_misses", 256'(miss_cnt), 256'(0));
      @(negedge clk);
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      #1;
      chk("tp5_late_gnt_req", 256'(mem_req), 256'(0));
      chk("tp5_late_gnt_miss", 256'(miss), 256'(0));
      access(1'b1, 1'b0, 32'h0000_0040, 4'h0, 32'd0, 0);
      chk("tp5_reload_misses", 256'(miss_cnt), 256'(1));
      chk("tp5_reload_rd", 256'(rd_data), 256'(32'h1111_1111));

      access(1'b1, 1'b1, 32'h0000_0048, 4'hF, 32'h5555_5555, 0);
      access(1'b1, 1'b0, 32'h0000_0048, 4'h0, 32'd0, 0);
      chk("tp6_rd", 256'(rd_data), 256'(32'h5555_5555));

      for (int i = 0; i < 300; i++) begin
         a = {18'd0, 6'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
         if ($urandom_range(0, 9) == 0) a[31:14] = 18'($urandom_range(1, 262143));
         op = int'($urandom_range(0, 2));
         access(op != 1, op != 0, a, 4'($urandom), $urandom, 0);
         if ($urandom_range(0, 3) == 0) idle_cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
